mem_arbiter: RTL and testbench

- Two-port arbiter between the instruction cache (port 0) and the data cache (port 1), and the single external word-granular memory interface.
- The arbiter locks the memory to one cache at a time, for the whole of that cache's burst (e.g. a 4-word line fill plus the write-through store).
- It routes in-order read responses back to the owning cache.
- It tracks outstanding reads so that ownership is never handed over while responses are still in flight.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: locks the memory to one cache per burst and steers in-order read data back to the owner.
// Latency: zero; the granted request reaches the memory combinationally in the same cycle.
// Backpressure: the owner's ready follows i_mem_ready and is held low at MAX_OUTSTANDING reads; the other port sees ready=0.
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_c0_addr,
    input  logic        i_c0_ren,
    input  logic        i_c0_wen,
    input  logic [31:0] i_c0_wdata,
    output logic        o_c0_ready,
    output logic [31:0] o_c0_rdata,
    output logic        o_c0_valid,
    input  logic [31:0] i_c1_addr,
    input  logic        i_c1_ren,
    input  logic        i_c1_wen,
    input  logic [31:0] i_c1_wdata,
    output logic        o_c1_ready,
    output logic [31:0] o_c1_rdata,
    output logic        o_c1_valid,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;
    logic          err_q;

    logic          req0, req1;
    logic          gnt_vld, gnt_sel;
    logic          g_ren, g_wen, g_rdy;
    logic          full, rd_acc, resp;

    assign req0 = i_c0_ren | i_c0_wen;
    assign req1 = i_c1_ren | i_c1_wen;

    // Grant is suppressed while reset is held so the memory side goes quiet at once.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (!i_rst) begin
            case (state_q)
                OWN0: begin
                    gnt_vld = 1'b1;
                    gnt_sel = 1'b0;
                end
                OWN1: begin
                    gnt_vld = 1'b1;
                    gnt_sel = 1'b1;
                end
                default: begin
                    if (req0 && req1) begin
                        gnt_vld = 1'b1;
                        gnt_sel = rr_q;
                    end else if (req0) begin
                        gnt_vld = 1'b1;
                        gnt_sel = 1'b0;
                    end else if (req1) begin
                        gnt_vld = 1'b1;
                        gnt_sel = 1'b1;
                    end
                end
            endcase
        end
    end

    assign full   = (cnt_q == CW'(MAX_OUTSTANDING));
    assign g_ren  = gnt_vld & (gnt_sel ? i_c1_ren : i_c0_ren);
    assign g_wen  = gnt_vld & (gnt_sel ? i_c1_wen : i_c0_wen);
    assign g_rdy  = gnt_vld & i_mem_ready & ~(g_ren & full);

    assign o_mem_addr  = !gnt_vld ? 32'd0 : (gnt_sel ? i_c1_addr  : i_c0_addr);
    assign o_mem_wdata = !gnt_vld ? 32'd0 : (gnt_sel ? i_c1_wdata : i_c0_wdata);
    assign o_mem_ren   = g_ren & ~full;
    assign o_mem_wen   = g_wen;
    assign o_c0_ready  = g_rdy & ~gnt_sel;
    assign o_c1_ready  = g_rdy & gnt_sel;

    assign rd_acc = o_mem_ren & i_mem_ready;
    assign resp   = i_mem_valid & (cnt_q != '0);

    assign o_c0_rdata = i_mem_rdata;
    assign o_c1_rdata = i_mem_rdata;
    assign o_c0_valid = resp & (state_q == OWN0);
    assign o_c1_valid = resp & (state_q == OWN1);
    assign o_err      = err_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({rd_acc, resp})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Ownership is only released once every read of the burst has returned.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) state_d = gnt_sel ? OWN1 : OWN0;
            end
            OWN0: begin
                if (cnt_d == '0 && !req0) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            OWN1: begin
                if (cnt_d == '0 && !req1) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            err_q   <= err_q | (i_mem_valid & (cnt_q == '0));
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, conflict/fairness, outstanding limit, stalled write, stray response, async reset.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_c0_addr, i_c0_wdata, i_c1_addr, i_c1_wdata;
    logic        i_c0_ren, i_c0_wen, i_c1_ren, i_c1_wen;
    logic        o_c0_ready, o_c0_valid, o_c1_ready, o_c1_valid;
    logic [31:0] o_c0_rdata, o_c1_rdata;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_c0_addr(i_c0_addr), .i_c0_ren(i_c0_ren), .i_c0_wen(i_c0_wen), .i_c0_wdata(i_c0_wdata),
        .o_c0_ready(o_c0_ready), .o_c0_rdata(o_c0_rdata), .o_c0_valid(o_c0_valid),
        .i_c1_addr(i_c1_addr), .i_c1_ren(i_c1_ren), .i_c1_wen(i_c1_wen), .i_c1_wdata(i_c1_wdata),
        .o_c1_ready(o_c1_ready), .o_c1_rdata(o_c1_rdata), .o_c1_valid(o_c1_valid),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 1ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic acc;
        i_rst = 1'b1;
        i_c0_addr = 0; i_c0_ren = 0; i_c0_wen = 0; i_c0_wdata = 0;
        i_c1_addr = 0; i_c1_ren = 0; i_c1_wen = 0; i_c1_wdata = 0;
        i_mem_ready = 0; i_mem_valid = 0; i_mem_rdata = 0;
        tick();
        #1;
        expect_eq("rst_c0_ready", {31'd0, o_c0_ready}, 0);
        expect_eq("rst_c1_ready", {31'd0, o_c1_ready}, 0);
        expect_eq("rst_valids", {30'd0, o_c0_valid, o_c1_valid}, 0);
        expect_eq("rst_mem_rw", {30'd0, o_mem_ren, o_mem_wen}, 0);
        expect_eq("rst_err", {31'd0, o_err}, 0);
        tick();
        i_rst = 1'b0;
        tick();

        // Single read on port 1, response two cycles later.
        i_c1_addr = 32'h100; i_c1_ren = 1; i_mem_ready = 1;
        #1;
        expect_eq("rd1_mem_ren", {31'd0, o_mem_ren}, 1);
        expect_eq("rd1_c1_ready", {31'd0, o_c1_ready}, 1);
        expect_eq("rd1_addr", o_mem_addr, 32'h100);
        expect_eq("rd1_c0_ready", {31'd0, o_c0_ready}, 0);
        tick();
        i_c1_ren = 0;
        #1;
        expect_eq("rd1_c1_valid_c1", {31'd0, o_c1_valid}, 0);
        tick();
        i_mem_valid = 1; i_mem_rdata = 32'hDEADBEEF;
        #1;
        expect_eq("rd1_c1_valid_c2", {31'd0, o_c1_valid}, 1);
        expect_eq("rd1_c1_rdata", o_c1_rdata, 32'hDEADBEEF);
        expect_eq("rd1_c0_valid", {31'd0, o_c0_valid}, 0);
        tick();
        i_mem_valid = 0;
        #1;
        expect_eq("rd1_idle_ready", {31'd0, o_c1_ready}, 0);
        tick();

        // Both ports read at once: port 0 wins (rr=0) and keeps the memory for its burst.
        i_c0_ren = 1; i_c1_ren = 1; i_c1_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            i_c0_addr = 32'h40 + 32'(4 * i);
            #1;
            expect_eq($sformatf("cf_addr%0d", i), o_mem_addr, 32'h40 + 32'(4 * i));
            expect_eq($sformatf("cf_c0_ready%0d", i), {31'd0, o_c0_ready}, 1);
            expect_eq($sformatf("cf_c1_ready%0d", i), {31'd0, o_c1_ready}, 0);
            tick();
        end
        i_c0_ren = 0;
        for (int i = 0; i < 4; i++) begin
            i_mem_valid = 1; i_mem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            expect_eq($sformatf("cf_c0_valid%0d", i), {31'd0, o_c0_valid}, 1);
            expect_eq($sformatf("cf_c0_rdata%0d", i), o_c0_rdata, 32'hA000_0000 + 32'(i));
            expect_eq($sformatf("cf_c1_wait%0d", i), {30'd0, o_c1_ready, o_c1_valid}, 0);
            tick();
        end
        i_mem_valid = 0;
        // Second conflict: rr now favours port 1.
        i_c0_ren = 1; i_c0_addr = 32'h80;
        #1;
        expect_eq("cf2_c1_ready", {31'd0, o_c1_ready}, 1);
        expect_eq("cf2_c0_ready", {31'd0, o_c0_ready}, 0);
        expect_eq("cf2_addr", o_mem_addr, 32'h300);
        tick();
        i_c1_ren = 0;
        i_mem_valid = 1; i_mem_rdata = 32'h3333;
        #1;
        expect_eq("cf2_c1_valid", {31'd0, o_c1_valid}, 1);
        tick();
        i_mem_valid = 0;
        #1;
        expect_eq("cf3_c0_ready", {31'd0, o_c0_ready}, 1);
        tick();
        i_c0_ren = 0;
        tick();
        i_mem_valid = 1; i_mem_rdata = 32'h8080;
        #1;
        expect_eq("cf3_c0_valid", {31'd0, o_c0_valid}, 1);
        tick();
        i_mem_valid = 0;
        tick();

        // Outstanding limit: four reads accepted, the fifth stalls until a response.
        i_c1_ren = 1;
        for (int i = 0; i < 4; i++) begin
            i_c1_addr = 32'h500 + 32'(4 * i);
            #1;
            expect_eq($sformatf("full_acc%0d", i), {31'd0, o_c1_ready}, 1);
            tick();
        end
        i_c1_addr = 32'h510;
        #1;
        expect_eq("full_c1_ready", {31'd0, o_c1_ready}, 0);
        expect_eq("full_mem_ren", {31'd0, o_mem_ren}, 0);
        tick();
        i_mem_valid = 1; i_mem_rdata = 32'h5000;
        #1;
        expect_eq("full_resp_valid", {31'd0, o_c1_valid}, 1);
        acc = o_c1_ready;
        tick();
        i_mem_valid = 0;
        for (int n = 0; n < 3 && !acc; n++) begin
            #1;
            acc = o_c1_ready;
            tick();
        end
        expect_eq("full_fifth_acc", {31'd0, acc}, 1);
        i_c1_addr = 32'h514;
        #1;
        expect_eq("full_again_ready", {31'd0, o_c1_ready}, 0);
        expect_eq("full_again_ren", {31'd0, o_mem_ren}, 0);
        tick();
        i_c1_ren = 0;
        for (int i = 0; i < 4; i++) begin
            i_mem_valid = 1; i_mem_rdata = 32'h5100 + 32'(i);
            #1;
            expect_eq($sformatf("full_drain%0d", i), {31'd0, o_c1_valid}, 1);
            tick();
        end
        i_mem_valid = 0;
        #1;
        expect_eq("full_idle_ready", {31'd0, o_c1_ready}, 0);
        expect_eq("full_err", {31'd0, o_err}, 0);
        tick();

        // Write stalled by memory for two cycles.
        i_c1_addr = 32'h200; i_c1_wdata = 32'h12345678; i_c1_wen = 1; i_mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            expect_eq($sformatf("wr_wen%0d", i), {31'd0, o_mem_wen}, 1);
            expect_eq($sformatf("wr_addr%0d", i), o_mem_addr, 32'h200);
            expect_eq($sformatf("wr_data%0d", i), o_mem_wdata, 32'h12345678);
            expect_eq($sformatf("wr_ready%0d", i), {31'd0, o_c1_ready}, 0);
            tick();
        end
        i_mem_ready = 1;
        #1;
        expect_eq("wr_ready2", {31'd0, o_c1_ready}, 1);
        expect_eq("wr_ren", {31'd0, o_mem_ren}, 0);
        tick();
        i_c1_wen = 0;
        #1;
        expect_eq("wr_no_valid", {31'd0, o_c1_valid}, 0);
        tick();
        #1;
        expect_eq("wr_idle_ready", {31'd0, o_c1_ready}, 0);
        expect_eq("wr_err", {31'd0, o_err}, 0);
        tick();

        // Stray response in IDLE.
        i_mem_valid = 1; i_mem_rdata = 32'hBAD0;
        #1;
        expect_eq("stray_valids", {30'd0, o_c0_valid, o_c1_valid}, 0);
        tick();
        i_mem_valid = 0;
        #1;
        expect_eq("stray_err", {31'd0, o_err}, 1);
        tick();
        tick();
        expect_eq("stray_err_sticky", {31'd0, o_err}, 1);

        // Asynchronous reset in the middle of a port 0 burst.
        i_rst = 1;
        tick();
        i_rst = 0;
        #1;
        expect_eq("rst2_err", {31'd0, o_err}, 0);
        i_c0_ren = 1; i_c0_addr = 32'h600;
        tick();
        i_c0_addr = 32'h604;
        tick();
        i_c0_addr = 32'h608;
        #1;
        expect_eq("rst2_pre_ren", {31'd0, o_mem_ren}, 1);
        #1;
        i_rst = 1;
        #1;
        expect_eq("rst2_mem_rw", {30'd0, o_mem_ren, o_mem_wen}, 0);
        expect_eq("rst2_ready", {30'd0, o_c0_ready, o_c1_ready}, 0);
        expect_eq("rst2_valid", {30'd0, o_c0_valid, o_c1_valid}, 0);
        i_c0_ren = 0;
        tick();
        i_rst = 0;
        #1;
        expect_eq("rst2_idle_ready", {31'd0, o_c0_ready}, 0);
        i_mem_valid = 1; i_mem_rdata = 32'h6000;
        #1;
        expect_eq("rst2_stray_valid", {31'd0, o_c0_valid}, 0);
        tick();
        i_mem_valid = 0;
        #1;
        expect_eq("rst2_stray_err", {31'd0, o_err}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
